halt_controller: RTL

Core-side counterpart of the run controller: converts the `run` level into a core enable, watches the retiring instruction stream for EBREAK, and raises the `ebreak` halt request that the run controller consumes to drop `run`. It also keeps run-length statistics (cycles and retired instructions) for the filter firmware benchmarks, and flags a halt that the run controller never acknowledged. It sits between the run controller and the RISC-V core's PC/stall logic.

---
 rtl/halt_controller.sv | 116 +++++++++++
 1 files changed

// File: rtl/halt_controller.sv
// Core-side halt controller: turns the run level into a core enable, raises an
// EBREAK halt request, and keeps run-length statistics for the last run.
module halt_controller #(
    parameter int          CNT_W        = 32,
    parameter int          HALT_TIMEOUT = 15,
    parameter logic [31:0] EBREAK_WORD  = 32'h0010_0073
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    output logic             core_en,
    output logic             ebreak,
    output logic             halted,
    output logic             halt_err,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count,
    output logic [1:0]       state
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RUN      = 2'd1;
    localparam logic [1:0] HALT_REQ = 2'd2;
    localparam logic [1:0] HALTED   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [7:0]       TIMEOUT_LAST = 8'(HALT_TIMEOUT - 1);

    // Handshake: ebreak is a level held from the EBREAK retirement until run
    // is seen low (normal ack) or the timeout expires; it never pulses.

    logic       run_q;
    logic       seen_low;
    logic [7:0] timeout_count;
    logic       start;
    logic       is_ebreak;

    // seen_low blocks a start from a run level that was already high at reset release.
    assign start     = run & ~run_q & seen_low;
    assign is_ebreak = instr_valid && (instr == EBREAK_WORD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            run_q         <= 1'b0;
            seen_low      <= 1'b0;
            timeout_count <= 8'd0;
            core_en       <= 1'b0;
            ebreak        <= 1'b0;
            halted        <= 1'b0;
            halt_err      <= 1'b0;
            cycle_count   <= '0;
            instr_count   <= '0;
        end else begin
            run_q <= run;
            if (!run) begin
                seen_low <= 1'b1;
            end

            case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        state       <= RUN;
                        core_en     <= 1'b1;
                        cycle_count <= '0;
                        instr_count <= '0;
                        halt_err    <= 1'b0;
                        halted      <= 1'b0;
                    end
                end

                RUN: begin
                    if (is_ebreak) begin
                        // EBREAK beats a simultaneous external stop; it is not counted.
                        state         <= HALT_REQ;
                        core_en       <= 1'b0;
                        ebreak        <= 1'b1;
                        timeout_count <= 8'd0;
                        if (cycle_count != CNT_MAX) begin
                            cycle_count <= cycle_count + 1'b1;
                        end
                    end else if (!run) begin
                        state   <= IDLE;
                        core_en <= 1'b0;
                    end else begin
                        if (cycle_count != CNT_MAX) begin
                            cycle_count <= cycle_count + 1'b1;
                        end
                        if (instr_valid && (instr_count != CNT_MAX)) begin
                            instr_count <= instr_count + 1'b1;
                        end
                    end
                end

                HALT_REQ: begin
                    if (!run) begin
                        state  <= HALTED;
                        ebreak <= 1'b0;
                        halted <= 1'b1;
                    end else if (timeout_count == TIMEOUT_LAST) begin
                        state    <= HALTED;
                        ebreak   <= 1'b0;
                        halted   <= 1'b1;
                        halt_err <= 1'b1;
                    end else begin
                        timeout_count <= timeout_count + 8'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
